// File: rtl/quiz_pkg.sv
// quiz_pkg: shared types for the quiz show host controller.
//   state_t  : host FSM states (CLEAR, ARMED, ANSWER)
//   NONE/PUPIL/HIGH/PROF : winner encoding driven on the winner port
package quiz_pkg;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    ARMED  = 2'd1,
    ANSWER = 2'd2
  } state_t;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] PUPIL = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] PROF  = 2'd3;

endpackage

// File: rtl/quiz_answer_timer.sv
// quiz_answer_timer: loadable down-counter for the answer window.
//   clk, rst : clock, asynchronous active-high reset
//   load     : start a new window of TIMEOUT_CYCLES cycles
//   run      : window continues past this cycle (decrement)
//   expire   : last cycle of the window is in progress
//   active   : registered, high while a window is running
// Dropping both load and run ends the window immediately, so active
// tracks the controller's ANSWER state exactly.
module quiz_answer_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire,
  output logic active
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= CW'(TIMEOUT_CYCLES);
      active <= 1'b1;
    end else if (run) begin
      cnt    <= cnt - CW'(1);
      active <= 1'b1;
    end else begin
      cnt    <= '0;
      active <= 1'b0;
    end
  end

  assign expire = active && (cnt == CW'(1));

endmodule

// File: rtl/quiz_host_controller.sv
// quiz_host_controller: host side of the quiz buzzer system.
// Watches the lockout judge lamps, runs a timed answer window, applies the
// host's correct/wrong judgement to per-group scores and pulses X5 to re-arm.
//   clk, rst        : clock, asynchronous active-high reset
//   Y0, Y1, Y2      : lamps (pupils, high school, professors)
//   ok_btn, bad_btn : host judgement buttons (synchronous, debounced)
//   new_game        : clear all scores and re-arm
//   X5              : clear line to the lockout judge
//   winner          : 0 none, 1 pupils, 2 high school, 3 professors
//   timer_active    : answer window running
//   timeout         : one-cycle pulse on window expiry
//   score0..score2  : saturating group scores
// Build option: define QUIZ_PENALTY_EN to make wrong answers and timeouts
// decrement the winner's score (saturating at 0).
module quiz_host_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CLEAR_CYCLES   = 2,
  parameter int unsigned SCORE_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Y0,
  input  logic               Y1,
  input  logic               Y2,
  input  logic               ok_btn,
  input  logic               bad_btn,
  input  logic               new_game,
  output logic               X5,
  output logic [1:0]         winner,
  output logic               timer_active,
  output logic               timeout,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2
);

  import quiz_pkg::*;

  localparam int unsigned CCW = $clog2(CLEAR_CYCLES + 1);

  state_t         state;
  logic [CCW-1:0] clr_cnt;
  logic           ok_q, bad_q;
  logic           in_ans, ok_e, bad_e, judge_ok, judge_bad;
  logic           win_lamp, drop, expire, leave, run, load, tmo;

  quiz_answer_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .run    (run),
    .expire (expire),
    .active (timer_active)
  );

  // Exit priority in ANSWER: new_game > single judgement edge > lamp drop
  // > expiry. Simultaneous ok/bad edges cancel and are not a judgement.
  always_comb begin
    in_ans    = (state == ANSWER);
    ok_e      = ok_btn & ~ok_q;
    bad_e     = bad_btn & ~bad_q;
    judge_ok  = in_ans & ok_e & ~bad_e;
    judge_bad = in_ans & bad_e & ~ok_e;
    case (winner)
      PUPIL:   win_lamp = Y0;
      HIGH:    win_lamp = Y1;
      PROF:    win_lamp = Y2;
      default: win_lamp = 1'b0;
    endcase
    drop  = in_ans & ~win_lamp & ~judge_ok & ~judge_bad;
    tmo   = in_ans & expire & ~new_game & ~judge_ok & ~judge_bad & ~drop;
    leave = in_ans & (new_game | judge_ok | judge_bad | drop | expire);
    run   = in_ans & ~leave;
    load  = (state == ARMED) & (Y0 | Y1 | Y2) & ~new_game;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      X5      <= 1'b1;
      winner  <= NONE;
      timeout <= 1'b0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      // Edge history is held at 0 outside ANSWER so a button already held
      // on entry counts as an edge in the first ANSWER cycle.
      ok_q    <= in_ans & ok_btn;
      bad_q   <= in_ans & bad_btn;
      if (new_game) begin
        state   <= CLEAR;
        clr_cnt <= '0;
        X5      <= 1'b1;
      end else begin
        case (state)
          CLEAR: begin
            if (clr_cnt == CCW'(CLEAR_CYCLES - 1)) begin
              state   <= ARMED;
              clr_cnt <= '0;
              X5      <= 1'b0;
              winner  <= NONE;
            end else begin
              clr_cnt <= clr_cnt + CCW'(1);
            end
          end
          ARMED: begin
            if (Y0 | Y1 | Y2) begin
              state  <= ANSWER;
              winner <= Y0 ? PUPIL : (Y1 ? HIGH : PROF);
            end
          end
          ANSWER: begin
            if (leave) begin
              state   <= CLEAR;
              clr_cnt <= '0;
              X5      <= 1'b1;
              timeout <= tmo;
            end
          end
          default: state <= CLEAR;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score0 <= '0;
      score1 <= '0;
      score2 <= '0;
    end else if (new_game) begin
      score0 <= '0;
      score1 <= '0;
      score2 <= '0;
    end else if (judge_ok) begin
      case (winner)
        PUPIL:   if (score0 != '1) score0 <= score0 + 1'b1;
        HIGH:    if (score1 != '1) score1 <= score1 + 1'b1;
        PROF:    if (score2 != '1) score2 <= score2 + 1'b1;
        default: ;
      endcase
`ifdef QUIZ_PENALTY_EN
    end else if (judge_bad | tmo) begin
      case (winner)
        PUPIL:   if (score0 != '0) score0 <= score0 - 1'b1;
        HIGH:    if (score1 != '0) score1 <= score1 - 1'b1;
        PROF:    if (score2 != '0) score2 <= score2 - 1'b1;
        default: ;
      endcase
`endif
    end
  end

endmodule

// File: doc/quiz_host_controller.md
# quiz_host_controller

Host-side controller for the quiz show buzzer system; it sits at the other end of the lockout judge. It watches the three group lamps (Y0 pupils, Y1 high school, Y2 professors) and runs a timed answer window. It takes the host's correct/wrong judgement, keeps per-group scores, and drives the host clear line X5 to re-arm the lockout for the next question.

## Interface
- TIMEOUT_CYCLES, 1000: length of the answer window in clk cycles (≥2)
- CLEAR_CYCLES, 2: number of cycles X5 is held high per re-arm (≥1)
- SCORE_W, 4: width of each score counter
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- Y0, Y1, Y2  in  1 each  lamp outputs of the lockout judge
- ok_btn  in  1  host "correct" button, synchronous to clk, debounced upstream
- bad_btn  in  1  host "wrong" button, synchronous to clk, debounced upstream
- new_game  in  1  synchronous clear of all scores, then re-arm
- X5  out  1  host clear to the lockout judge
- winner  out  2  0 = none, 1 = pupils, 2 = high school, 3 = professors
- timer_active  out  1  high while the answer window runs
- timeout  out  1  one-cycle pulse when the window expires
- score0, score1, score2  out  SCORE_W each  group scores

## Operation
- FSM states: CLEAR, ARMED, ANSWER.
- Reset values: state CLEAR with clear counter at 0, X5=1, winner=0, timer_active=0, timeout=0, all scores 0.
- CLEAR: X5=1 for exactly CLEAR_CYCLES cycles, then go to ARMED. winner holds its last value.
- ARMED: X5=0 and winner=0. Any lamp high moves the FSM to ANSWER and latches winner.
  - Lamp priority when several are high in one cycle: Y0 > Y1 > Y2.
- ANSWER: timer_active=1. ok_btn and bad_btn are rising-edge detected.
  - ok edge: score[winner] +1, saturating at 2^SCORE_W−1. Go to CLEAR.
  - bad edge: score[winner] −1, saturating at 0 (see Configuration). Go to CLEAR.
  - ok and bad edges in the same cycle: both ignored, window keeps running.
  - Window expiry: handled as a bad edge; timeout pulses on the transition cycle.
  - Latched winner's lamp drops before judgement: go to CLEAR with no score change and no timeout.
- A judgement edge arriving in the same cycle as expiry takes precedence over the timeout.
- new_game (any state): all scores set to 0 on the next edge; FSM goes to CLEAR with clear counter restarted. new_game overrides a judgement in the same cycle.
- Button edge detectors reset to 0. A button already held when ANSWER is entered therefore counts as an edge on the first ANSWER cycle.
- Reset mid-operation returns everything to reset values immediately (asynchronous).

## Timing
- Lamp high at edge n while ARMED: state=ANSWER, winner and timer_active valid after edge n+1.
- Timer loads TIMEOUT_CYCLES on ANSWER entry and decrements once per ANSWER cycle.
  - With no judgement, the FSM leaves ANSWER exactly TIMEOUT_CYCLES cycles after entry.
  - timeout=1 for the first CLEAR cycle only.
- Judgement edge sampled at edge n: updated score and X5=1 visible after edge n+1. Latency 1 cycle.
- X5 high for CLEAR_CYCLES cycles, then ARMED. Lamps are not sampled while in CLEAR.
- Score arithmetic is SCORE_W unsigned with saturation. It never wraps.

## Configuration
- QUIZ_PENALTY_EN defined: bad edge and timeout decrement score[winner], saturating at 0.
- QUIZ_PENALTY_EN undefined: bad edge and timeout leave scores unchanged. All FSM transitions, X5 behaviour and the timeout pulse are identical in both builds.

## Structure
- Shared package quiz_pkg holds:
  - the FSM state enum (CLEAR, ARMED, ANSWER)
  - the group/winner encoding constants (NONE=0, PUPIL=1, HIGH=2, PROF=3)
- Sub-module quiz_answer_timer holds the loadable down-counter.
  - Inputs: load and run.
  - Outputs: expire and active.
- Score registers and the FSM stay in the top module.

## Test plan
All scenarios use TIMEOUT_CYCLES=8, CLEAR_CYCLES=2, SCORE_W=4.
- After rst release: X5=1 for 2 cycles, then 0. Y1 high → winner=2 next cycle. ok_btn edge → score1=1, X5=1 for 2 cycles.
- Y2 high, no judgement → timer_active for 8 cycles, then timeout pulse of 1 cycle. score2 stays 0 with penalty (saturates at 0) and is unchanged without penalty.
- Y0 and Y2 high in the same cycle → winner=1.
- Y0, then 16 ok rounds → score0 saturates at 15 and the 16th ok leaves it at 15. With QUIZ_PENALTY_EN, one bad round → 14.
- ok and bad edges in the same cycle → no score change, window keeps running. Y0 then drops → CLEAR with no score change and no timeout.
- new_game asserted during ANSWER with score1=5 → all scores 0 and X5=1 next cycle. rst asserted mid-ANSWER → immediate X5=1, winner=0, timer_active=0.
